// File: rtl/ring_store.sv
// ring_store: write side of the serial ring buffer with occupancy tracking and read strobe generation
module ring_store #(
  parameter int counter_size = 4,
  parameter int buffer_size  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    txda,
  input  logic                    txc,
  input  logic                    rd_req,
  output logic [buffer_size-1:0]  buffer,
  output logic [2*counter_size:0] ramadrs,
  output logic                    outstrobe,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);
  localparam logic [counter_size:0] depth = (counter_size+1)'(buffer_size);
  logic [counter_size-1:0] wptr, rptr, rd_addr;
  logic [counter_size:0]   count;
  logic                    wr_ok, rd_ok;
  // flags come from the registered count only, so a same-cycle read never frees a slot for a write
  always_comb begin
    full    = count == depth;
    empty   = count == '0;
    wr_ok   = txc && !full;
    rd_ok   = rd_req && !empty;
    ramadrs = {full, wptr, rd_addr};
  end
  // storage, pointers, occupancy and the one-cycle read strobe
  always_ff @(posedge clock) begin
    if (!reset) begin
      buffer    <= '0;
      wptr      <= '0;
      rptr      <= '0;
      rd_addr   <= '0;
      count     <= '0;
      outstrobe <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        buffer[wptr] <= txda;
        wptr         <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rd_addr <= rptr;
        rptr    <= rptr + 1'b1;
      end
      outstrobe <= rd_ok;
      if (txc && full) overflow <= 1'b1;
      count <= count + (counter_size+1)'(wr_ok) - (counter_size+1)'(rd_ok);
    end
  end
endmodule
